// File: rtl/mod_arith_pkg.sv
// ============================================================================
//  Module   : mod_arith_pkg
//  Purpose  : Shared widths, FSM encoding and sizing helpers for the
//             digit-serial modular arithmetic blocks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_arith_pkg;

    localparam int c_w_default = 256;
    localparam int c_d_default = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ndig(input int w, input int d);
        return w / d;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_subadd.sv
// ============================================================================
//  Module   : digit_subadd
//  Purpose  : One D-bit digit of a - b - bw followed by d + q + cy.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_subadd #(
    parameter int D = 64
) (
    input  logic [D-1:0] a_i,
    input  logic [D-1:0] b_i,
    input  logic [D-1:0] q_i,
    input  logic         bw_in,
    input  logic         cy_in,
    output logic [D-1:0] d_i,
    output logic [D-1:0] e_i,
    output logic         bw_out,
    output logic         cy_out
);

    logic [D:0] w_diff;
    logic [D:0] w_sum;

    // D+1-bit difference: the top bit is set exactly when the digit borrows
    assign w_diff = {1'b0, a_i} - {1'b0, b_i} - {{D{1'b0}}, bw_in};
    assign d_i    = w_diff[D-1:0];
    assign bw_out = w_diff[D];

    assign w_sum  = {1'b0, w_diff[D-1:0]} + {1'b0, q_i} + {{D{1'b0}}, cy_in};
    assign e_i    = w_sum[D-1:0];
    assign cy_out = w_sum[D];

endmodule

`default_nettype wire

// File: rtl/mod_sub_serial.sv
// ============================================================================
//  Module   : mod_sub_serial
//  Purpose  : Digit-serial (a - b) mod q, D bits per cycle, LSB digit first,
//             with valid/ready handshakes on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_sub_serial
    import mod_arith_pkg::*;
#(
    parameter int W = c_w_default,
    parameter int D = c_d_default
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] q,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result
);

    localparam int                 c_ndig  = ndig(W, D);
    localparam int                 c_cnt_w = cnt_width(c_ndig);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(c_ndig - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [W-1:0]       r_a, r_b, r_q;
    logic [W-1:0]       r_d, r_e;
    logic [W-1:0]       w_d_next, w_e_next;
    logic               r_bw, r_cy, r_sel;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_accept, w_last;
    logic [D-1:0]       w_d_i, w_e_i;
    logic               w_bw_out, w_cy_out;

    digit_subadd #(.D(D)) u_digit (
        .a_i    (r_a[D-1:0]),
        .b_i    (r_b[D-1:0]),
        .q_i    (r_q[D-1:0]),
        .bw_in  (r_bw),
        .cy_in  (r_cy),
        .d_i    (w_d_i),
        .e_i    (w_e_i),
        .bw_out (w_bw_out),
        .cy_out (w_cy_out)
    );

    // New digits enter at the MSB end so digit 0 lands at the LSB after NDIG shifts
    generate
        if (c_ndig == 1) begin : g_single_digit
            assign w_d_next = w_d_i;
            assign w_e_next = w_e_i;
        end else begin : g_multi_digit
            assign w_d_next = {w_d_i, r_d[W-1:D]};
            assign w_e_next = {w_e_i, r_e[W-1:D]};
        end
    endgenerate

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == c_last);
    assign result   = r_sel ? r_e : r_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_q   <= '0;
            r_d   <= '0;
            r_e   <= '0;
            r_bw  <= 1'b0;
            r_cy  <= 1'b0;
            r_sel <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_q   <= q;
            r_bw  <= 1'b0;
            r_cy  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> D;
            r_b   <= r_b >> D;
            r_q   <= r_q >> D;
            r_d   <= w_d_next;
            r_e   <= w_e_next;
            r_bw  <= w_bw_out;
            r_cy  <= w_cy_out;
            r_cnt <= r_cnt + c_cnt_w'(1);
            // Final borrow means a < b, so the q-corrected value is the answer
            if (w_last) begin
                r_sel <= w_bw_out;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mod_sub_serial.sv
// ============================================================================
//  Module   : tb_mod_sub_serial
//  Purpose  : Self-checking bench for mod_sub_serial at 16/4 and 256/64.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_sub_serial;

    localparam logic [255:0] c_p256 =
        256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    localparam logic [15:0]  c_qs   = 16'hFFF1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [15:0] s_a, s_b, s_q, s_result;

    logic         g_in_valid, g_in_ready, g_out_valid, g_out_ready;
    logic [255:0] g_a, g_b, g_q, g_result;

    int total = 0;
    int bad   = 0;

    mod_sub_serial #(.W(16), .D(4)) u_small (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .a         (s_a),
        .b         (s_b),
        .q         (s_q),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .result    (s_result)
    );

    mod_sub_serial #(.W(256), .D(64)) u_big (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (g_in_valid),
        .in_ready  (g_in_ready),
        .a         (g_a),
        .b         (g_b),
        .q         (g_q),
        .out_valid (g_out_valid),
        .out_ready (g_out_ready),
        .result    (g_result)
    );

    // Reference: mathematical (a - b) mod q for reduced operands
    function automatic logic [15:0] ref_small(input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] q);
        int unsigned ai = a, bi = b, qi = q;
        if (ai >= bi) return 16'(ai - bi);
        return 16'(ai + qi - bi);
    endfunction

    function automatic logic [255:0] ref_big(input logic [255:0] a, input logic [255:0] b,
                                             input logic [255:0] q);
        logic [256:0] t;
        if (a >= b) t = {1'b0, a} - {1'b0, b};
        else        t = {1'b0, a} + {1'b0, q} - {1'b0, b};
        return t[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] x;
        for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
        return x;
    endfunction

    // One complete operation on the 16-bit instance; lat counts the cycle in which out_valid is seen
    task automatic run_small(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                             output logic [15:0] res, output int lat, output bit to);
        int w;
        @(posedge clk); #1;
        s_a = a; s_b = b; s_q = q; s_in_valid = 1'b1; s_out_ready = 1'b0;
        w = 0;
        while (!s_in_ready && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        s_a = 16'($urandom); s_b = 16'($urandom); s_q = 16'($urandom);
        lat = 1;
        while (!s_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        to  = !s_out_valid;
        res = s_result;
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
    endtask

    task automatic run_big(input logic [255:0] a, input logic [255:0] b, input logic [255:0] q,
                           output logic [255:0] res, output int lat, output bit to);
        int w;
        @(posedge clk); #1;
        g_a = a; g_b = b; g_q = q; g_in_valid = 1'b1; g_out_ready = 1'b0;
        w = 0;
        while (!g_in_ready && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        g_in_valid = 1'b0;
        g_a = rand256(); g_b = rand256(); g_q = rand256();
        lat = 1;
        while (!g_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        to  = !g_out_valid;
        res = g_result;
        g_out_ready = 1'b1;
        @(posedge clk); #1;
        g_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_in_valid = 1'b1; s_a = 16'h0007; s_b = 16'h0005; s_q = c_qs;
        g_in_valid = 1'b1; g_a = 256'd1; g_b = 256'd2; g_q = c_p256;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        s_in_valid = 1'b0;
        g_in_valid = 1'b0;
        total++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_result !== 16'h0) begin
            bad++;
            $display("FAIL reset_small: in_ready=%b out_valid=%b result=%h, want 1 0 0000",
                     s_in_ready, s_out_valid, s_result);
        end
        total++;
        if (g_in_ready !== 1'b1 || g_out_valid !== 1'b0 || g_result !== 256'h0) begin
            bad++;
            $display("FAIL reset_big: in_ready=%b out_valid=%b result=%h, want 1 0 0",
                     g_in_ready, g_out_valid, g_result);
        end
    endtask

    task automatic test_basic();
        logic [15:0] va[4] = '{16'h0007, 16'h0005, 16'h0000, 16'h1234};
        logic [15:0] vb[4] = '{16'h0005, 16'h0007, 16'hFFF0, 16'h1234};
        logic [15:0] ve[4] = '{16'h0002, 16'hFFEF, 16'h0001, 16'h0000};
        logic [15:0] res;
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            run_small(va[i], vb[i], c_qs, res, lat, to);
            total++;
            if (to || res !== ve[i]) begin
                bad++;
                $display("FAIL basic_result[%0d]: got=%h want=%h timeout=%0b", i, res, ve[i], to);
            end
            total++;
            if (lat != 5) begin
                bad++;
                $display("FAIL basic_latency[%0d]: got=%0d want=5", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] r0;
        logic [15:0] exp_v = 16'hFEF1;
        int w;
        @(posedge clk); #1;
        s_a = 16'h0100; s_b = 16'h0200; s_q = c_qs; s_in_valid = 1'b1; s_out_ready = 1'b0;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        w = 0;
        while (!s_out_valid && w < 50) begin @(posedge clk); #1; w++; end
        total++;
        if (!s_out_valid || s_result !== exp_v) begin
            bad++;
            $display("FAIL bp_result: out_valid=%b got=%h want=%h", s_out_valid, s_result, exp_v);
        end
        r0 = s_result;
        for (int i = 0; i < 6; i++) begin
            s_in_valid = 1'b1;
            s_a = 16'($urandom % 16'hFFF1); s_b = 16'($urandom % 16'hFFF1);
            @(posedge clk); #1;
            total++;
            if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 || s_result !== r0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b result=%h, want 1 0 %h",
                         i, s_out_valid, s_in_ready, s_result, r0);
            end
        end
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        total++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", s_in_ready, s_out_valid);
        end
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_no_accept: out_valid=%b in_ready=%b, want 0 1", s_out_valid, s_in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] res;
        int lat, w;
        bit to, seen;
        @(posedge clk); #1;
        s_a = 16'h0123; s_b = 16'h0456; s_q = c_qs; s_in_valid = 1'b1; s_out_ready = 1'b0;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_result !== 16'h0) begin
            bad++;
            $display("FAIL reset_run: in_ready=%b out_valid=%b result=%h, want 1 0 0000",
                     s_in_ready, s_out_valid, s_result);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (s_out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_run_abort: out_valid seen=1 want 0");
        end
        run_small(16'd9, 16'd3, c_qs, res, lat, to);
        total++;
        if (to || res !== 16'h0006 || lat != 5) begin
            bad++;
            $display("FAIL reset_run_next: got=%h lat=%0d, want 0006 lat=5", res, lat);
        end
        // Abort from DONE
        @(posedge clk); #1;
        s_a = 16'h0002; s_b = 16'h0001; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        w = 0;
        while (!s_out_valid && w < 50) begin @(posedge clk); #1; w++; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || w >= 50) begin
            bad++;
            $display("FAIL reset_done: in_ready=%b out_valid=%b wait=%0d, want 1 0 <50",
                     s_in_ready, s_out_valid, w);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int outs;
        logic [15:0] ea, eb, exp_v;
        ea = 16'($urandom % 16'hFFF1);
        eb = 16'($urandom % 16'hFFF1);
        exp_v = ref_small(ea, eb, c_qs);
        @(posedge clk); #1;
        s_a = ea; s_b = eb; s_q = c_qs; s_in_valid = 1'b1; s_out_ready = 1'b1;
        outs = 0;
        for (int c = 0; c < 30; c++) begin
            if (s_in_valid && s_in_ready) acc.push_back(c);
            if (s_out_valid) begin
                outs++;
                total++;
                if (s_result !== exp_v) begin
                    bad++;
                    $display("FAIL b2b_result: got=%h want=%h", s_result, exp_v);
                end
            end
            @(posedge clk); #1;
        end
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
        total++;
        if (acc.size() < 3 || outs < 4) begin
            bad++;
            $display("FAIL b2b_count: accepts=%0d outputs=%0d, want >=3 >=4", acc.size(), outs);
        end else begin
            total++;
            if (acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6) begin
                bad++;
                $display("FAIL b2b_period: got=%0d,%0d want=6,6", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_random_small();
        logic [15:0] q, a, b, res, exp_v;
        int lat;
        bit to;
        for (int i = 0; i < 200; i++) begin
            q = 16'($urandom_range(1, 16'hFFFF));
            a = 16'($urandom % q);
            b = 16'($urandom % q);
            exp_v = ref_small(a, b, q);
            run_small(a, b, q, res, lat, to);
            total++;
            if (to || res !== exp_v || lat != 5) begin
                bad++;
                $display("FAIL rand_small[%0d]: a=%h b=%h q=%h got=%h want=%h lat=%0d",
                         i, a, b, q, res, exp_v, lat);
            end
        end
    endtask

    task automatic test_big();
        logic [255:0] a, b, res, exp_v;
        int lat;
        bit to;
        run_big(256'd1, 256'd2, c_p256, res, lat, to);
        total++;
        if (to || res !== c_p256 - 256'd1 || lat != 5) begin
            bad++;
            $display("FAIL big_p256_1m2: got=%h lat=%0d want q-1 lat=5", res, lat);
        end
        for (int i = 0; i < 1000; i++) begin
            a = rand256(); if (a >= c_p256) a = a - c_p256;
            b = rand256(); if (b >= c_p256) b = b - c_p256;
            if (i % 50 == 0) b = a;
            exp_v = ref_big(a, b, c_p256);
            run_big(a, b, c_p256, res, lat, to);
            total++;
            if (to || res !== exp_v) begin
                bad++;
                $display("FAIL big_rand[%0d]: got=%h want=%h timeout=%0b", i, res, exp_v, to);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_q = c_qs;
        g_in_valid = 1'b0; g_out_ready = 1'b0; g_a = '0; g_b = '0; g_q = c_p256;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random_small();
        test_big();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
